// File: rtl/corescore_pkt_fifo.sv
// Store-and-forward byte FIFO: releases a packet only once its tlast byte is stored.
// Optional in-flight packet counter (o_pkts) enabled by defining CORESCORE_PKT_FIFO_STATS_EN.
module corescore_pkt_fifo #(
    parameter int AW = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   i_tdata,
    input  logic         i_tlast,
    input  logic         i_tvalid,
    output logic         o_tready,
    output logic [7:0]   o_tdata,
    output logic         o_tlast,
    output logic         o_tvalid,
    input  logic         i_tready
`ifdef CORESCORE_PKT_FIFO_STATS_EN
    ,
    output logic [AW:0]  o_pkts
`endif
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] cmt_ptr_q, cmt_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        force_q, force_d;
    logic        tvalid_q, tvalid_d;
    logic [7:0]  tdata_q;
    logic        tlast_q;

    logic full, avail, wr_en, rd_en, force_commit;

    // Full when the pointers differ only in the wrap bit.
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign avail        = (cmt_ptr_q != rd_ptr_q);
    assign wr_en        = i_tvalid && !full;
    assign rd_en        = avail && (!tvalid_q || i_tready);
    assign force_commit = full && !avail;

    assign o_tready = !full;
    assign o_tvalid = tvalid_q;
    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        force_d   = force_q;
        tvalid_d  = tvalid_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            // An oversize packet already cut through keeps committing every byte.
            if (i_tlast || force_q) begin
                cmt_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (i_tlast) begin
                force_d = 1'b0;
            end
        end else if (force_commit) begin
            cmt_ptr_d = wr_ptr_q;
            force_d   = 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            tvalid_d = 1'b1;
        end else if (i_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            force_q   <= 1'b0;
            tvalid_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            force_q   <= force_d;
            tvalid_q  <= tvalid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {i_tlast, i_tdata};
        end
    end

    // Output register doubles as the registered read port of the buffer memory.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tdata_q <= 8'h00;
            tlast_q <= 1'b0;
        end else if (rd_en) begin
            {tlast_q, tdata_q} <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef CORESCORE_PKT_FIFO_STATS_EN
    logic [AW:0] pkts_q, pkts_d;
    logic        pkt_in, pkt_out;

    assign pkt_in  = wr_en && i_tlast;
    assign pkt_out = tvalid_q && i_tready && tlast_q;
    assign o_pkts  = pkts_q;

    always_comb begin
        pkts_d = pkts_q;
        if (pkt_in && !pkt_out && (pkts_q != '1)) begin
            pkts_d = pkts_q + PTR_ONE;
        end else if (pkt_out && !pkt_in && (pkts_q != '0)) begin
            pkts_d = pkts_q - PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkts_q <= '0;
        end else begin
            pkts_q <= pkts_d;
        end
    end
`endif

endmodule

// File: tb/tb_corescore_pkt_fifo.sv
// Self-checking bench for corescore_pkt_fifo (AW=3): directed scenarios plus a
// randomized stream checked against a queue model of the byte stream.
module tb_corescore_pkt_fifo;

    localparam int AW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [7:0]    i_tdata = 8'h00;
    logic          i_tlast = 1'b0;
    logic          i_tvalid = 1'b0;
    logic          i_tready = 1'b0;
    logic          o_tready;
    logic [7:0]    o_tdata;
    logic          o_tlast;
    logic          o_tvalid;
`ifdef CORESCORE_PKT_FIFO_STATS_EN
    logic [AW:0]   o_pkts;
`endif

    int checks = 0;
    int errors = 0;
    int emit_cnt = 0;
    int tlast_cnt = 0;
    logic [8:0] last_emit = 9'h000;
    logic [8:0] sbq[$];

    corescore_pkt_fifo #(.AW(AW)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready)
`ifdef CORESCORE_PKT_FIFO_STATS_EN
        ,
        .o_pkts   (o_pkts)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference model: every accepted beat is queued, every emitted beat must
    // match the queue head; a stalled beat must hold still.
    task automatic monitor();
        logic [8:0] exp_beat;
        logic [8:0] stall_beat;
        bit         prev_stall;
        prev_stall = 1'b0;
        stall_beat = 9'h000;
        forever begin
            @(negedge i_clk);
            if (i_rst !== 1'b0) begin
                sbq.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (o_tvalid !== 1'b1 || {o_tlast, o_tdata} !== stall_beat) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b beat=%h, expected valid=1 beat=%h",
                                 o_tvalid, {o_tlast, o_tdata}, stall_beat);
                    end
                end
                if (i_tvalid && o_tready) sbq.push_back({i_tlast, i_tdata});
                if (o_tvalid && i_tready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL stream_order: got beat=%h, expected no beat", {o_tlast, o_tdata});
                    end else begin
                        exp_beat = sbq.pop_front();
                        if ({o_tlast, o_tdata} !== exp_beat) begin
                            errors++;
                            $display("FAIL stream_order: got beat=%h, expected %h",
                                     {o_tlast, o_tdata}, exp_beat);
                        end
                    end
                    emit_cnt++;
                    if (o_tlast) tlast_cnt++;
                    last_emit = {o_tlast, o_tdata};
                end
                prev_stall = (o_tvalid === 1'b1) && !i_tready;
                stall_beat = {o_tlast, o_tdata};
            end
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int  n;
        bit  done;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge i_clk);
            if (o_tready) done = 1'b1;
            cycle();
            n++;
        end
        i_tvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted in %0d cycles, expected acceptance", d, n);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((sbq.size() != 0 || o_tvalid !== 1'b0) && n < max_cycles) begin
            cycle();
            n++;
        end
        checks++;
        if (sbq.size() != 0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats pending after %0d cycles, expected 0", sbq.size(), n);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_tvalid = 1'b0;
        i_tready = 1'b0;
        repeat (2) cycle();
        i_rst = 1'b0;
        checks += 4;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", o_tvalid); end
        if (o_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", o_tdata); end
        if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b expected 0", o_tlast); end
        if (o_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %0b expected 1", o_tready); end
`ifdef CORESCORE_PKT_FIFO_STATS_EN
        checks++;
        if (o_pkts !== '0) begin errors++; $display("FAIL reset_pkts: got %0d expected 0", o_pkts); end
`endif
    endtask

    task automatic test_basic();
        logic [8:0] exp_beats [3];
        exp_beats[0] = {1'b0, 8'h41};
        exp_beats[1] = {1'b0, 8'h42};
        exp_beats[2] = {1'b1, 8'h0A};
        i_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_beat(exp_beats[k][7:0], exp_beats[k][8]);
            checks++;
            if (o_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL basic_hold: got tvalid=%0b after beat %0d, expected 0", o_tvalid, k);
            end
        end
        cycle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_tvalid !== 1'b1 || {o_tlast, o_tdata} !== exp_beats[k]) begin
                errors++;
                $display("FAIL basic_out%0d: got valid=%0b beat=%h, expected valid=1 beat=%h",
                         k, o_tvalid, {o_tlast, o_tdata}, exp_beats[k]);
            end
            cycle();
        end
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_end: got tvalid=%0b expected 0", o_tvalid); end
    endtask

    task automatic test_capacity();
        int n;
        int got;
        i_tready = 1'b0;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            i_tvalid = 1'b1;
            i_tdata  = 8'(8'h10 + n);
            i_tlast  = (n % 4 == 3);
            @(negedge i_clk);
            if (o_tready) n++;
            cycle();
        end
        i_tvalid = 1'b0;
        checks += 3;
        if (n != 9) begin errors++; $display("FAIL cap_count: got %0d accepted, expected 9", n); end
        if (o_tready !== 1'b0) begin errors++; $display("FAIL cap_full: got tready=%0b expected 0", o_tready); end
        if (o_tvalid !== 1'b1 || o_tdata !== 8'h10) begin
            errors++;
            $display("FAIL cap_head: got valid=%0b data=%h, expected valid=1 data=10", o_tvalid, o_tdata);
        end
        i_tready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_tvalid) begin
                got++;
                checks++;
                if (o_tdata !== 8'(8'h10 + got - 1) || o_tlast !== (got % 4 == 0)) begin
                    errors++;
                    $display("FAIL cap_drain%0d: got %h/%0b, expected %h/%0b", got, o_tdata, o_tlast,
                             8'(8'h10 + got - 1), (got % 4 == 0));
                end
            end
            cycle();
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL cap_drained: got %0d bytes, expected 8", got); end
        send_beat(8'h19, 1'b0);
        send_beat(8'h1A, 1'b0);
        send_beat(8'h1B, 1'b1);
        wait_idle(50);
    endtask

    task automatic test_oversize();
        int e0;
        int t0;
        e0 = emit_cnt;
        t0 = tlast_cnt;
        i_tready = 1'b1;
        for (int k = 0; k < 12; k++) send_beat(8'(k), (k == 11));
        wait_idle(60);
        checks += 2;
        if (emit_cnt - e0 != 12) begin errors++; $display("FAIL oversize_count: got %0d expected 12", emit_cnt - e0); end
        if (tlast_cnt - t0 != 1) begin errors++; $display("FAIL oversize_tlast: got %0d expected 1", tlast_cnt - t0); end
    endtask

    task automatic test_random();
        int  e0;
        int  t0;
        int  total;
        bit  drv_done;
        e0 = emit_cnt;
        t0 = tlast_cnt;
        total = 0;
        drv_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) begin
                        repeat ($urandom_range(0, 2)) cycle();
                        send_beat(8'($urandom), (b == len - 1));
                        total++;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (!(drv_done && sbq.size() == 0 && o_tvalid === 1'b0) && c < 20000) begin
                    i_tready = ($urandom_range(0, 99) < 60);
                    cycle();
                    c++;
                end
            end
        join
        i_tready = 1'b1;
        checks += 3;
        if (sbq.size() != 0) begin errors++; $display("FAIL rand_left: got %0d pending expected 0", sbq.size()); end
        if (emit_cnt - e0 != total) begin errors++; $display("FAIL rand_bytes: got %0d expected %0d", emit_cnt - e0, total); end
        if (tlast_cnt - t0 != 200) begin errors++; $display("FAIL rand_pkts: got %0d expected 200", tlast_cnt - t0); end
    endtask

    task automatic test_reset_mid();
        int e0;
        i_tready = 1'b1;
        send_beat(8'h31, 1'b0);
        send_beat(8'h32, 1'b0);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        checks += 2;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %0b expected 0", o_tvalid); end
        if (o_tready !== 1'b1) begin errors++; $display("FAIL rstmid_tready: got %0b expected 1", o_tready); end
        e0 = emit_cnt;
        send_beat(8'h55, 1'b1);
        wait_idle(20);
        checks += 2;
        if (emit_cnt - e0 != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", emit_cnt - e0); end
        if (last_emit !== 9'h155) begin errors++; $display("FAIL rstmid_beat: got %h expected 155", last_emit); end
    endtask

`ifdef CORESCORE_PKT_FIFO_STATS_EN
    task automatic test_stats();
        bit hs;
        int n;
        i_tready = 1'b0;
        checks++;
        if (o_pkts !== '0) begin errors++; $display("FAIL stats_idle: got %0d expected 0", o_pkts); end
        for (int p = 0; p < 3; p++) begin
            send_beat(8'(8'h60 + 2 * p), 1'b0);
            send_beat(8'(8'h61 + 2 * p), 1'b1);
        end
        checks++;
        if (o_pkts !== 4'd3) begin errors++; $display("FAIL stats_three: got %0d expected 3", o_pkts); end
        i_tready = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 20) begin
            @(negedge i_clk);
            if (o_tvalid && o_tlast) hs = 1'b1;
            cycle();
            n++;
        end
        i_tready = 1'b0;
        checks++;
        if (o_pkts !== 4'd2) begin errors++; $display("FAIL stats_two: got %0d expected 2", o_pkts); end
        i_tready = 1'b1;
        wait_idle(30);
        checks++;
        if (o_pkts !== 4'd0) begin errors++; $display("FAIL stats_zero: got %0d expected 0", o_pkts); end
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_capacity();
        test_oversize();
        test_random();
        test_reset_mid();
`ifdef CORESCORE_PKT_FIFO_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
